adc_capture_buf: RTL and testbench
==================================

# adc_capture_buf

Triggered pre/post-trigger capture buffer for the synchronized I/Q sample stream, sitting directly downstream of the ADC data-sync stage. It is clocked by the recovered ADC clock. On arm, it records samples into a circular dual-port RAM until a level-crossing trigger (or a forced trigger) fires. It then fills the remaining depth and flags done; downstream logic reads the frame through a random-access read port.

## Interface
- DW, 16, sample width per channel (two's complement)
- AW, 10, address width; DEPTH = 2**AW sample pairs
- sys_clk  in  1  capture/read clock (ADC output clock domain)
- rst_n  in  1  asynchronous active-low reset
- i_adi_din  in  DW  I-channel sample
- i_adq_din  in  DW  Q-channel sample
- i_din_vl  in  1  sample pair valid, one pair per high cycle
- i_arm  in  1  single-cycle pulse: start (or restart) a capture
- i_force_trig  in  1  single-cycle pulse: request a trigger regardless of level
- i_trig_level  in  DW  signed trigger threshold, compared on the I channel
- i_trig_edge  in  1  0 = rising crossing, 1 = falling crossing
- i_pre_len  in  AW  pre-trigger sample count; sampled on arm
- i_rd_en  in  1  read request
- i_rd_addr  in  AW  read address
- o_rd_adi  out  DW  read I data
- o_rd_adq  out  DW  read Q data
- o_rd_vl  out  1  read data valid
- o_state  out  3  current FSM state code
- o_busy  out  1  high in PRE, WAIT_TRIG, POST
- o_done  out  1  capture complete (level)
- o_trig_addr  out  AW  RAM address of the trigger sample
- o_start_addr  out  AW  RAM address of the oldest sample in the frame

## Operation
- The FSM has five states: IDLE=0, PRE=1, WAIT_TRIG=2, POST=3, DONE=4. State only advances on cycles where i_din_vl=1, except for arm handling.
- Arm, in any state:
  - wr_ptr←0, pre_cnt←0, post_cnt←0.
  - pre_len latched from i_pre_len; post_len = DEPTH − pre_len, computed in AW+1 bits.
  - prev-sample flag cleared, force latch cleared, o_done←0.
  - Next state is PRE, or WAIT_TRIG if pre_len=0.
  - Any sample valid in the arm cycle is ignored.
- Write: in PRE, WAIT_TRIG and POST, each valid pair is written to RAM[wr_ptr], then wr_ptr increments modulo DEPTH. No writes occur in IDLE or DONE.
- PRE: count valid samples. When the pre_len-th sample is written, go to WAIT_TRIG.
- WAIT_TRIG:
  - Writing continues circularly, overwriting the oldest samples.
  - Rising trigger: prev < level and cur ≥ level, signed compare.
  - Falling trigger: prev > level and cur ≤ level, signed compare.
  - A level trigger requires the prev flag to be set. The flag sets after the first valid sample following arm. prev is updated on every valid sample from PRE onward, so a crossing between the last PRE sample and the first WAIT_TRIG sample counts.
  - A force pulse in PRE or WAIT_TRIG sets the force latch. The next valid sample in WAIT_TRIG is then a trigger.
  - Trigger sample: o_trig_addr←wr_ptr, o_start_addr←(wr_ptr − pre_len) mod DEPTH. The trigger sample counts as post sample 1; go to POST.
- POST: when post_cnt reaches post_len (written sample included), go to DONE.
- DONE: o_done=1 and held until the next arm or reset. The frame spans DEPTH samples starting at o_start_addr and wrapping.
- Read port:
  - Always active; reads are not blocked during a capture, and contents are then unspecified.
  - Data registered: o_rd_* reflect i_rd_addr from the previous cycle, and o_rd_vl = i_rd_en delayed by 1.
  - A read and write to the same address in the same cycle returns the old data.

## Timing
- Reset values: state IDLE, o_state=0, o_busy=0, o_done=0, o_trig_addr=0, o_start_addr=0, o_rd_adi=0, o_rd_adq=0, o_rd_vl=0. RAM contents are not reset.
- Arm at cycle t: o_state and o_busy update at t+1. o_done falls at t+1.
- Trigger sample valid at cycle t: o_state=3 and o_trig_addr valid at t+1.
- Last POST sample at cycle t: o_state=4, o_done=1, o_busy=0 at t+1.
- Arm and force in the same cycle: arm wins and the force latch is cleared.
- Arm mid-capture: the current capture is aborted immediately, with no done pulse.
- Reset mid-capture: return to IDLE asynchronously.
- Read latency: exactly 1 cycle.

## Test plan
- AW=4, pre_len=4, edge=0, level=100, continuous I ramp 0,10,20,…: the trigger occurs at I=100. o_done=1 one cycle after 12 post samples. Reading from o_start_addr gives I=60…210 in order.
- Same setup, with i_din_vl toggling 1/0: identical frame contents. Done is delayed only by the idle cycles.
- pre_len=0, level never crossed, force pulse in WAIT_TRIG: the next valid sample is the trigger with o_trig_addr=o_start_addr. 16 samples are captured.
- First sample after arm already ≥ level: no trigger on that sample. A later genuine rising crossing does trigger.
- Falling edge, level=−50, I sequence 0,−40,−60: the trigger is at I=−60.
- Re-arm during POST: busy stays high, done never asserts for the aborted run, and a fresh capture completes. Assert rst_n low mid-PRE: all outputs return to reset values.

Source files
------------

// File: rtl/adc_capture_buf_if.sv
// adc_capture_buf_if: sample stream, trigger control, read port and status of the capture buffer
interface adc_capture_buf_if #(
    parameter int DW = 16,
    parameter int AW = 10
);
    logic [DW-1:0] i_adi_din;
    logic [DW-1:0] i_adq_din;
    logic          i_din_vl;
    logic          i_arm;
    logic          i_force_trig;
    logic [DW-1:0] i_trig_level;
    logic          i_trig_edge;
    logic [AW-1:0] i_pre_len;
    logic          i_rd_en;
    logic [AW-1:0] i_rd_addr;
    logic [DW-1:0] o_rd_adi;
    logic [DW-1:0] o_rd_adq;
    logic          o_rd_vl;
    logic [2:0]    o_state;
    logic          o_busy;
    logic          o_done;
    logic [AW-1:0] o_trig_addr;
    logic [AW-1:0] o_start_addr;

    modport slave (
        input  i_adi_din, i_adq_din, i_din_vl, i_arm, i_force_trig,
               i_trig_level, i_trig_edge, i_pre_len, i_rd_en, i_rd_addr,
        output o_rd_adi, o_rd_adq, o_rd_vl, o_state, o_busy, o_done,
               o_trig_addr, o_start_addr
    );

    modport master (
        output i_adi_din, i_adq_din, i_din_vl, i_arm, i_force_trig,
               i_trig_level, i_trig_edge, i_pre_len, i_rd_en, i_rd_addr,
        input  o_rd_adi, o_rd_adq, o_rd_vl, o_state, o_busy, o_done,
               o_trig_addr, o_start_addr
    );
endinterface

// File: rtl/adc_capture_buf.sv
// adc_capture_buf: pre/post-trigger circular capture of I/Q pairs with a registered random-access read port
module adc_capture_buf #(
    parameter int DW = 16,
    parameter int AW = 10
) (
    input logic            sys_clk,
    input logic            rst_n,
    adc_capture_buf_if.slave bus
);
    localparam int DEPTH = 2 ** AW;
    localparam logic [AW-1:0] one_a = 1;
    localparam logic [AW:0]   one_p = 1;
    localparam logic [AW:0]   depth_p = {1'b1, {AW{1'b0}}};

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRE       = 3'd1,
        WAIT_TRIG = 3'd2,
        POST      = 3'd3,
        DONE      = 3'd4
    } state_t;

    state_t               state;
    logic [AW-1:0]        wr_ptr, pre_len, pre_cnt, trig_addr, start_addr;
    logic [AW:0]          post_len, post_cnt;
    logic signed [DW-1:0] prev, cur, lvl;
    logic                 prev_vl, force_l, done, cap, we, rise, fall, hit, rd_vl;
    logic [2*DW-1:0]      mem [DEPTH];
    logic [2*DW-1:0]      rd_q;

    assign cur = $signed(bus.i_adi_din);
    assign lvl = $signed(bus.i_trig_level);
    assign cap = state == PRE || state == WAIT_TRIG || state == POST;

    // write strobe and trigger detection for the sample presented this cycle
    always_comb begin
        we   = bus.i_din_vl && !bus.i_arm && cap;
        rise = prev < lvl && cur >= lvl;
        fall = prev > lvl && cur <= lvl;
        hit  = force_l || (prev_vl && (bus.i_trig_edge ? fall : rise));
    end

    // capture sequencer: arm restarts from any state, otherwise advance on valid samples
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            pre_len    <= '0;
            pre_cnt    <= '0;
            post_len   <= '0;
            post_cnt   <= '0;
            prev       <= '0;
            prev_vl    <= 1'b0;
            force_l    <= 1'b0;
            done       <= 1'b0;
            trig_addr  <= '0;
            start_addr <= '0;
        end else if (bus.i_arm) begin
            state    <= bus.i_pre_len == '0 ? WAIT_TRIG : PRE;
            wr_ptr   <= '0;
            pre_len  <= bus.i_pre_len;
            pre_cnt  <= '0;
            post_len <= depth_p - {1'b0, bus.i_pre_len};
            post_cnt <= '0;
            prev_vl  <= 1'b0;
            force_l  <= 1'b0;
            done     <= 1'b0;
        end else begin
            if (bus.i_force_trig && (state == PRE || state == WAIT_TRIG))
                force_l <= 1'b1;
            if (we) begin
                wr_ptr  <= wr_ptr + one_a;
                prev    <= cur;
                prev_vl <= 1'b1;
                case (state)
                    PRE: begin
                        pre_cnt <= pre_cnt + one_a;
                        if (pre_cnt + one_a == pre_len)
                            state <= WAIT_TRIG;
                    end
                    WAIT_TRIG: if (hit) begin
                        trig_addr  <= wr_ptr;
                        start_addr <= wr_ptr - pre_len;
                        post_cnt   <= one_p;
                        state      <= post_len == one_p ? DONE : POST;
                        done       <= post_len == one_p;
                    end
                    POST: begin
                        post_cnt <= post_cnt + one_p;
                        if (post_cnt + one_p == post_len) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // sample RAM write port, Q in the upper half
    always_ff @(posedge sys_clk) begin
        if (we)
            mem[wr_ptr] <= {bus.i_adq_din, bus.i_adi_din};
    end

    // registered read port; a same-cycle write to the address returns the old word
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q  <= '0;
            rd_vl <= 1'b0;
        end else begin
            rd_q  <= mem[bus.i_rd_addr];
            rd_vl <= bus.i_rd_en;
        end
    end

    assign bus.o_rd_adi     = rd_q[DW-1:0];
    assign bus.o_rd_adq     = rd_q[2*DW-1:DW];
    assign bus.o_rd_vl      = rd_vl;
    assign bus.o_state      = state;
    assign bus.o_busy       = cap;
    assign bus.o_done       = done;
    assign bus.o_trig_addr  = trig_addr;
    assign bus.o_start_addr = start_addr;
endmodule

// File: tb/tb_adc_capture_buf.sv
// tb_adc_capture_buf: directed and randomized checks of the capture buffer against a sample-index model
module tb_adc_capture_buf;
    localparam int DW = 16;
    localparam int AW = 4;
    localparam int D  = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    adc_capture_buf_if #(.DW(DW), .AW(AW)) bus ();

    adc_capture_buf #(.DW(DW), .AW(AW)) dut (
        .sys_clk(clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // model: samples since arm are numbered 0,1,..; everything follows from those indices
    logic          armed;
    int            n, tk, pl, lastv;
    logic          fl;
    int            e_trig, e_start, e_rd, e_rq;
    logic          e_rvl, e_rkn;
    logic [DW-1:0] mi [D];
    logic [DW-1:0] mq [D];
    logic          mv [D];

    initial for (int i = 0; i < D; i++) mv[i] = 1'b0;

    function automatic logic crossed(input int p, input int c);
        int l;
        l = int'($signed(bus.i_trig_level));
        return bus.i_trig_edge ? (p > l && c <= l) : (p < l && c >= l);
    endfunction

    function automatic logic mdone();
        return tk >= 0 && (n - tk) >= (D - pl);
    endfunction

    function automatic int est();
        if (!armed) return 0;
        if (tk < 0) return n < pl ? 1 : 2;
        return mdone() ? 4 : 3;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // model update on each clock, inputs being stable around the edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed = 1'b0; n = 0; tk = -1; pl = 0; fl = 1'b0; lastv = 0;
            e_trig = 0; e_start = 0; e_rvl = 1'b0; e_rd = 0; e_rq = 0; e_rkn = 1'b1;
        end else begin
            e_rvl = bus.i_rd_en;
            e_rkn = mv[bus.i_rd_addr];
            e_rd  = int'($signed(mi[bus.i_rd_addr]));
            e_rq  = int'($signed(mq[bus.i_rd_addr]));
            if (bus.i_arm) begin
                armed = 1'b1; n = 0; tk = -1; fl = 1'b0;
                pl = int'(bus.i_pre_len);
            end else if (armed && !mdone()) begin
                if (bus.i_din_vl) begin
                    int c;
                    c = int'($signed(bus.i_adi_din));
                    if (tk < 0 && n >= pl && (fl || (n >= 1 && crossed(lastv, c)))) begin
                        tk = n;
                        e_trig = n % D;
                        e_start = (n - pl) % D;
                    end
                    mi[n % D] = bus.i_adi_din;
                    mq[n % D] = bus.i_adq_din;
                    mv[n % D] = 1'b1;
                    lastv = c;
                    n++;
                end
                if (bus.i_force_trig && tk < 0) fl = 1'b1;
            end
        end
    end

    // per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        int s;
        s = est();
        chk("state", int'(bus.o_state), s);
        chk("busy", int'(bus.o_busy), int'(s >= 1 && s <= 3));
        chk("done", int'(bus.o_done), int'(s == 4));
        chk("trig_addr", int'(bus.o_trig_addr), e_trig);
        chk("start_addr", int'(bus.o_start_addr), e_start);
        chk("rd_vl", int'(bus.o_rd_vl), int'(e_rvl));
        if (e_rkn) begin
            chk("rd_adi", int'($signed(bus.o_rd_adi)), e_rd);
            chk("rd_adq", int'($signed(bus.o_rd_adq)), e_rq);
        end
    end

    task automatic send(input logic vl, input int i, input int q, input logic arm, input logic frc);
        bus.i_din_vl     = vl;
        bus.i_adi_din    = DW'(i);
        bus.i_adq_din    = DW'(q);
        bus.i_arm        = arm;
        bus.i_force_trig = frc;
        @(posedge clk);
        #2;
    endtask

    task automatic setup(input int pre, input int lvl, input logic edg);
        bus.i_pre_len    = AW'(pre);
        bus.i_trig_level = DW'(lvl);
        bus.i_trig_edge  = edg;
        send(1'b1, 5, 5, 1'b1, 1'b0);
    endtask

    task automatic run_ramp(input logic toggle);
        setup(4, 100, 1'b0);
        chk("arm_state", int'(bus.o_state), 1);
        chk("arm_busy", int'(bus.o_busy), 1);
        for (int k = 0; k < 22; k++) begin
            if (k == 21) chk("ramp_not_done", int'(bus.o_done), 0);
            send(1'b1, k * 10, -k, 1'b0, 1'b0);
            if (k == 3) chk("ramp_pre_end", int'(bus.o_state), 2);
            if (k == 10) begin
                chk("ramp_trig_state", int'(bus.o_state), 3);
                chk("ramp_trig_addr", int'(bus.o_trig_addr), 10);
                chk("ramp_start_addr", int'(bus.o_start_addr), 6);
            end
            if (toggle && k != 21) send(1'b0, 999, 999, 1'b0, 1'b0);
        end
        chk("ramp_done", int'(bus.o_done), 1);
        chk("ramp_done_state", int'(bus.o_state), 4);
        chk("ramp_done_busy", int'(bus.o_busy), 0);
        for (int j = 0; j < D; j++) begin
            bus.i_rd_en   = 1'b1;
            bus.i_rd_addr = AW'(6 + j);
            send(1'b0, 0, 0, 1'b0, 1'b0);
            chk("frame_i", int'($signed(bus.o_rd_adi)), 60 + 10 * j);
            chk("frame_q", int'($signed(bus.o_rd_adq)), -(6 + j));
            chk("frame_vl", int'(bus.o_rd_vl), 1);
        end
        bus.i_rd_en = 1'b0;
        send(1'b0, 0, 0, 1'b0, 1'b0);
        chk("rd_vl_drop", int'(bus.o_rd_vl), 0);
    endtask

    initial begin
        bus.i_din_vl = 1'b0; bus.i_adi_din = '0; bus.i_adq_din = '0;
        bus.i_arm = 1'b0; bus.i_force_trig = 1'b0; bus.i_trig_level = '0;
        bus.i_trig_edge = 1'b0; bus.i_pre_len = '0; bus.i_rd_en = 1'b0; bus.i_rd_addr = '0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        chk("rst_state", int'(bus.o_state), 0);
        chk("rst_done", int'(bus.o_done), 0);
        chk("rst_rd_vl", int'(bus.o_rd_vl), 0);
        send(1'b1, 1, 1, 1'b0, 1'b0);
        chk("idle_stays", int'(bus.o_state), 0);

        run_ramp(1'b0);
        run_ramp(1'b1);

        setup(0, 30000, 1'b0);
        chk("force_arm_state", int'(bus.o_state), 2);
        for (int k = 0; k < 5; k++) send(1'b1, k, k, 1'b0, 1'b0);
        send(1'b0, 0, 0, 1'b0, 1'b1);
        chk("force_latched_wait", int'(bus.o_state), 2);
        send(1'b1, 5, 5, 1'b0, 1'b0);
        chk("force_trig_state", int'(bus.o_state), 3);
        chk("force_trig_addr", int'(bus.o_trig_addr), 5);
        chk("force_start_addr", int'(bus.o_start_addr), 5);
        for (int k = 6; k < 21; k++) begin
            if (k == 20) chk("force_not_done", int'(bus.o_done), 0);
            send(1'b1, k, k, 1'b0, 1'b0);
        end
        chk("force_done", int'(bus.o_done), 1);

        setup(0, 100, 1'b0);
        send(1'b1, 150, 0, 1'b0, 1'b0);
        chk("first_high_no_trig", int'(bus.o_state), 2);
        send(1'b1, 50, 0, 1'b0, 1'b0);
        chk("drop_no_trig", int'(bus.o_state), 2);
        send(1'b1, 120, 0, 1'b0, 1'b0);
        chk("late_rise_trig", int'(bus.o_state), 3);
        chk("late_rise_addr", int'(bus.o_trig_addr), 2);

        setup(1, -50, 1'b1);
        send(1'b1, 0, 0, 1'b0, 1'b0);
        send(1'b1, -40, 0, 1'b0, 1'b0);
        chk("fall_no_trig", int'(bus.o_state), 2);
        send(1'b1, -60, 0, 1'b0, 1'b0);
        chk("fall_trig_state", int'(bus.o_state), 3);
        chk("fall_trig_addr", int'(bus.o_trig_addr), 2);
        chk("fall_start_addr", int'(bus.o_start_addr), 1);

        for (int k = 0; k < 4; k++) send(1'b1, -70, 0, 1'b0, 1'b0);
        setup(2, 100, 1'b0);
        chk("rearm_busy", int'(bus.o_busy), 1);
        chk("rearm_state", int'(bus.o_state), 1);
        for (int k = 0; k < 24; k++) begin
            chk("rearm_no_done", int'(bus.o_done), 0);
            send(1'b1, k * 10, k, 1'b0, 1'b0);
        end
        chk("rearm_done", int'(bus.o_done), 1);
        chk("rearm_trig_addr", int'(bus.o_trig_addr), 10);
        chk("rearm_start_addr", int'(bus.o_start_addr), 8);

        bus.i_rd_en = 1'b1;
        setup(8, 100, 1'b0);
        for (int k = 0; k < 3; k++) send(1'b1, k, k, 1'b0, 1'b0);
        chk("mid_pre", int'(bus.o_state), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_state", int'(bus.o_state), 0);
        chk("arst_busy", int'(bus.o_busy), 0);
        chk("arst_trig", int'(bus.o_trig_addr), 0);
        chk("arst_start", int'(bus.o_start_addr), 0);
        chk("arst_rd_vl", int'(bus.o_rd_vl), 0);
        chk("arst_rd_i", int'(bus.o_rd_adi), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        bus.i_rd_en = 1'b0;

        for (int c = 0; c < 5000; c++) begin
            logic a, f, v;
            int   l;
            a = $urandom_range(0, 149) == 0;
            f = $urandom_range(0, 59) == 0;
            v = $urandom_range(0, 9) < 7;
            if (a) begin
                bus.i_pre_len    = AW'($urandom_range(0, D - 1));
                bus.i_trig_level = DW'(int'($urandom_range(0, 2000)) - 1000);
                bus.i_trig_edge  = 1'($urandom_range(0, 1));
            end
            l = int'($signed(bus.i_trig_level));
            bus.i_rd_en   = 1'($urandom_range(0, 1));
            bus.i_rd_addr = AW'($urandom_range(0, D - 1));
            send(v, l + int'($urandom_range(0, 200)) - 100, int'($urandom_range(0, 65535)), a, f);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
